ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//   Front end of the keyboard path: receives raw PS/2 (scan code set 2) frames from the keyboard pins
//   and turns them into key events for the game logic. Outputs are the 128-bit held-key map, the
//   9-bit last changed code {extended, byte} and a one-cycle key_valid strobe.
//   Sits between the board PS/2 pins and the typing/score counter block.
// PARAMETERS
//   TIMEOUT_CYC  100000  clk cycles with no PS/2 falling edge before a partial frame is abandoned
//   TO_W         17      width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC
// PORTS
//   clk          in   1    system clock
//   rst          in   1    reset, asynchronous, active-high
//   ps2_clk      in   1    PS/2 clock pin (asynchronous, idle high)
//   ps2_data     in   1    PS/2 data pin (asynchronous, idle high)
//   key_down     out  128  bit n = 1 while non-extended code n is held
//   last_change  out  9    {ext, byte} of the most recent make/break event
//   key_valid    out  1    one-cycle strobe; last_change/key_down updated in that same cycle
//   frame_err    out  1    one-cycle strobe on parity, stop or timeout error
// BEHAVIOUR
//   Reset: key_down=0, last_change=0, key_valid=0, frame_err=0, FSM=IDLE, bit count=0; sync flops=1.
//   Both pins pass 2-FF synchronisers. The falling edge of the synced ps2_clk is the sample strobe.
//   Frame: 11 bits = start(0), D0..D7 LSB first, parity, stop(1).
//   - start sampled as 1: bit discarded, bit count stays 0, no error.
//   - Good frame: ones(D7..D0,parity) is odd and stop==1. Byte done at the stop-bit sample cycle N.
//   - Bad parity or stop: frame_err=1 in cycle N+1, byte dropped, decoder FSM forced to IDLE.
//   Timeout: bit count != 0 and no falling edge for TIMEOUT_CYC cycles. Effect: bit count cleared,
//     frame_err=1 for one cycle, FSM to IDLE. Timeout counter restarts on every falling edge.
//   Decoder FSM (advances on each good byte b):
//     IDLE   : E0->EXT; F0->BRK; E1->PAUSE (cnt=7); b<=0x83 -> make {0,b}; other b ignored.
//     EXT    : F0->EXT_BRK; other b -> make {1,b}, back to IDLE.
//     BRK    : b -> break {0,b}, back to IDLE.
//     EXT_BRK: b -> break {1,b}, back to IDLE.
//     PAUSE  : swallow 7 bytes, no events, then IDLE.
//   Event: key_valid=1 and last_change<=code in cycle N+1 (one-cycle latency from the byte-done cycle).
//     If code[8:7]==0, key_down[code[6:0]] is set on make and cleared on break in the same cycle.
//     Extended codes and codes >=0x80 never touch key_down.
//   Break of a key not held: key_valid still pulses; the key_down bit stays 0.
//   key_valid and frame_err are never high in the same cycle. last_change holds its value between events.
//   Reset asserted mid-frame discards the partial frame and the prefix state; no strobe is produced.
// CONFIGURATION
//   REPEAT_FILTER_EN defined: a non-extended make whose key_down bit is already 1 (typematic repeat)
//     produces no key_valid and leaves last_change unchanged. Extended makes always pass.
//   Not defined: every make, including repeats, produces key_valid with last_change updated.
// TESTING
//   1 frame 0x1C (odd parity ok) -> key_valid one cycle, last_change=9'h01C, key_down[28]=1
//   2 after 1, frames F0,1C -> one key_valid only, on the 1C byte; last_change=9'h01C, key_down[28]=0
//   3 E0,75 then E0,F0,75 -> two key_valid, last_change=9'h175 each time, key_down stays all-zero
//   4 0x29 with flipped parity -> frame_err pulse, no key_valid; then good 0x29 -> key_down[41]=1
//   5 5 bits then idle TIMEOUT_CYC+1 cycles -> frame_err pulse; then frame 0x66 -> last_change=9'h066
//   6 0x29 twice (no break) -> with REPEAT_FILTER_EN: 1 key_valid; without: 2; also E1 pause sequence
//     E1,14,77,E1,F0,14,F0,77 -> zero key_valid and key_down unchanged

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: bundles the PS/2 pins and the decoded key-event outputs.
//   ps2_clk, ps2_data : PS/2 pins, driven by the keyboard side (master)
//   key_down          : 128-bit held-key map for non-extended codes
//   last_change       : {ext, byte} of the most recent make/break event
//   key_valid         : one-cycle event strobe
//   frame_err         : one-cycle parity/stop/timeout error strobe
interface ps2_key_decoder_if;
  logic         ps2_clk;
  logic         ps2_data;
  logic [127:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  key_down, last_change, key_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key_down, last_change, key_valid, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: receives PS/2 scan-code-set-2 frames and produces key events.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : ps2_key_decoder_if.slave (pins in; key_down, last_change, key_valid, frame_err out)
// Optional feature: define REPEAT_FILTER_EN to suppress typematic repeats of held
// non-extended keys.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned TO_W        = 17
) (
  input logic             clk,
  input logic             rst,
  ps2_key_decoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  // Pin synchronisers; clk_s3 is the previous synced clock for edge detection.
  logic clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1; clk_s3 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk;  clk_s2 <= clk_s1; clk_s3 <= clk_s2;
      dat_s1 <= bus.ps2_data; dat_s2 <= dat_s1;
    end
  end

  logic fall_c;
  assign fall_c = clk_s3 & ~clk_s2;

  // Frame receiver: bit_cnt 0 waits for start, 1..8 data, 9 parity, 10 stop.
  logic [3:0]      bit_cnt;
  logic [7:0]      rx_byte;
  logic            par;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_c, byte_done_c, good_c, err_c;

  assign timeout_c   = (bit_cnt != 4'd0) && !fall_c && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign byte_done_c = fall_c && (bit_cnt == 4'd10);
  assign good_c      = byte_done_c && dat_s2 && (^{rx_byte, par});
  assign err_c       = (byte_done_c && !good_c) || timeout_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 4'd0;
      rx_byte <= 8'd0;
      par     <= 1'b0;
      to_cnt  <= '0;
    end else if (fall_c) begin
      to_cnt <= '0;
      case (bit_cnt)
        4'd0:    if (!dat_s2) bit_cnt <= 4'd1;  // a high start bit is simply discarded
        4'd9:    begin par <= dat_s2; bit_cnt <= 4'd10; end
        4'd10:   bit_cnt <= 4'd0;
        default: begin rx_byte <= {dat_s2, rx_byte[7:1]}; bit_cnt <= bit_cnt + 4'd1; end
      endcase
    end else if (timeout_c) begin
      bit_cnt <= 4'd0;
      to_cnt  <= '0;
    end else if (bit_cnt != 4'd0) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  // Prefix decoder: state register.
  state_t     state, state_nxt;
  logic [2:0] pause_cnt, pause_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pause_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      pause_cnt <= pause_nxt;
    end
  end

  // Prefix decoder: next state, advanced once per good byte.
  always_comb begin
    state_nxt = state;
    pause_nxt = pause_cnt;
    if (err_c) begin
      state_nxt = IDLE;
    end else if (good_c) begin
      case (state)
        IDLE: begin
          if (rx_byte == 8'hE0)      state_nxt = EXT;
          else if (rx_byte == 8'hF0) state_nxt = BRK;
          else if (rx_byte == 8'hE1) begin state_nxt = PAUSE; pause_nxt = 3'd7; end
        end
        EXT:     state_nxt = (rx_byte == 8'hF0) ? EXT_BRK : IDLE;
        BRK:     state_nxt = IDLE;
        EXT_BRK: state_nxt = IDLE;
        PAUSE: begin
          pause_nxt = pause_cnt - 3'd1;
          if (pause_cnt == 3'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Prefix decoder: event generation for the byte completing in this cycle.
  logic         ev_c, make_c;
  logic [8:0]   code_c;
  logic [127:0] key_down_q;
  always_comb begin
    ev_c   = 1'b0;
    make_c = 1'b0;
    code_c = 9'd0;
    if (good_c) begin
      case (state)
        IDLE:    if (rx_byte <= 8'h83) begin ev_c = 1'b1; make_c = 1'b1; code_c = {1'b0, rx_byte}; end
        EXT:     if (rx_byte != 8'hF0) begin ev_c = 1'b1; make_c = 1'b1; code_c = {1'b1, rx_byte}; end
        BRK:     begin ev_c = 1'b1; code_c = {1'b0, rx_byte}; end
        EXT_BRK: begin ev_c = 1'b1; code_c = {1'b1, rx_byte}; end
        default: ev_c = 1'b0;
      endcase
    end
`ifdef REPEAT_FILTER_EN
    // Typematic repeat of a held plain key is swallowed; extended makes always pass.
    if (ev_c && make_c && (code_c[8:7] == 2'b00) && key_down_q[code_c[6:0]]) ev_c = 1'b0;
`endif
  end

  // Registered outputs, one cycle after the byte-done cycle.
  logic [8:0] last_change_q;
  logic       key_valid_q, frame_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_down_q    <= 128'd0;
      last_change_q <= 9'd0;
      key_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      key_valid_q <= ev_c;
      frame_err_q <= err_c;
      if (ev_c) begin
        last_change_q <= code_c;
        if (code_c[8:7] == 2'b00) key_down_q[code_c[6:0]] <= make_c;
      end
    end
  end

  assign bus.key_down    = key_down_q;
  assign bus.last_change = last_change_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: table-driven frame stimulus with an expected-strobe scoreboard,
// plus hand sequences for timeout, bad stop, high start bit and mid-frame reset.
module tb_ps2_key_decoder;
  localparam int unsigned TIMEOUT = 200;
  localparam int unsigned HALF    = 8;
`ifdef REPEAT_FILTER_EN
  localparam logic REP_EV = 1'b0;
`else
  localparam logic REP_EV = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_key_decoder_if bus();
  ps2_key_decoder #(.TIMEOUT_CYC(TIMEOUT), .TO_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic err; logic [8:0] code; } exp_t;
  typedef struct {
    logic [7:0] b; logic flip; logic ev; logic err; logic [8:0] code; int idx; logic kd;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge and strobes matched to the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst && (bus.key_valid || bus.frame_err)) begin
      check("strobe_exclusive", 128'(bus.key_valid & bus.frame_err), 128'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {bus.key_valid, bus.frame_err, bus.last_change}, 128'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {bus.key_valid, bus.frame_err}, e.err ? 128'd1 : 128'd2);
        if (!e.err) check("last_change", 128'(bus.last_change), 128'(e.code));
      end
    end
  endtask

  task automatic push_ev(input logic [8:0] code);
    exp_t e; e.err = 1'b0; e.code = code; exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e; e.err = 1'b1; e.code = 9'd0; exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic v);
    bus.ps2_data = v;
    repeat (HALF) tick();
    bus.ps2_clk = 1'b0;
    repeat (HALF) tick();
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip);
    send_bit(stop);
    bus.ps2_data = 1'b1;
    repeat (20) tick();
  endtask

  task automatic drain(input string name);
    check(name, 128'(exp_q.size()), 128'd0);
    exp_q.delete();
  endtask

  function automatic vec_t mk(input logic [7:0] b, input logic flip, input logic ev,
                              input logic err, input logic [8:0] code, input int idx, input logic kd);
    vec_t v;
    v.b = b; v.flip = flip; v.ev = ev; v.err = err; v.code = code; v.idx = idx; v.kd = kd;
    return v;
  endfunction

  initial begin
    tbl.push_back(mk(8'h1C, 0, 1, 0, 9'h01C, 28, 1));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 9'h000, 28, 1));
    tbl.push_back(mk(8'h1C, 0, 1, 0, 9'h01C, 28, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 9'h000, 117, 0));
    tbl.push_back(mk(8'h75, 0, 1, 0, 9'h175, 117, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 0, 9'h000, 117, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 9'h000, 117, 0));
    tbl.push_back(mk(8'h75, 0, 1, 0, 9'h175, 117, 0));
    tbl.push_back(mk(8'h29, 1, 0, 1, 9'h000, 41, 0));
    tbl.push_back(mk(8'h29, 0, 1, 0, 9'h029, 41, 1));
    tbl.push_back(mk(8'h29, 0, REP_EV, 0, 9'h029, 41, 1));
    tbl.push_back(mk(8'hE1, 0, 0, 0, 9'h000, 41, 1));
    tbl.push_back(mk(8'h14, 0, 0, 0, 9'h000, 20, 0));
    tbl.push_back(mk(8'h77, 0, 0, 0, 9'h000, 119, 0));
    tbl.push_back(mk(8'hE1, 0, 0, 0, 9'h000, 41, 1));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 9'h000, 41, 1));
    tbl.push_back(mk(8'h14, 0, 0, 0, 9'h000, 20, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 9'h000, 41, 1));
    tbl.push_back(mk(8'h77, 0, 0, 0, 9'h000, 119, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 9'h000, 41, 1));
    tbl.push_back(mk(8'h29, 0, 1, 0, 9'h029, 41, 0));
    tbl.push_back(mk(8'h83, 0, 1, 0, 9'h083, 3, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 0, 9'h000, 3, 0));
    tbl.push_back(mk(8'h83, 0, 1, 0, 9'h083, 3, 0));
    tbl.push_back(mk(8'h84, 0, 0, 0, 9'h000, 4, 0));
    tbl.push_back(mk(8'h05, 0, 1, 0, 9'h005, 5, 1));

    rst = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) tick();
    check("reset_key_down", bus.key_down, 128'd0);
    check("reset_last_change", 128'(bus.last_change), 128'd0);
    check("reset_strobes", 128'({bus.key_valid, bus.frame_err}), 128'd0);
    rst = 1'b0;
    repeat (5) tick();

    foreach (tbl[i]) begin
      if (tbl[i].ev)  push_ev(tbl[i].code);
      if (tbl[i].err) push_err();
      send_frame(tbl[i].b, tbl[i].flip, 1'b1);
      drain($sformatf("row%0d_strobes", i));
      check($sformatf("row%0d_key_down", i), 128'(bus.key_down[tbl[i].idx]), 128'(tbl[i].kd));
    end
    check("key_down_only_05", bus.key_down, 128'd1 << 5);

    // Partial frame abandoned after the idle timeout; last_change must hold.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    push_err();
    repeat (TIMEOUT + 10) tick();
    drain("timeout_err");
    check("timeout_hold_last", 128'(bus.last_change), 128'h005);
    push_ev(9'h066);
    send_frame(8'h66, 1'b0, 1'b1);
    drain("after_timeout_66");

    // Bad stop bit.
    push_err();
    send_frame(8'h1C, 1'b0, 1'b0);
    drain("bad_stop_err");
    check("bad_stop_kd28", 128'(bus.key_down[28]), 128'd0);

    // High start bit is ignored, next frame decodes normally.
    send_bit(1'b1);
    push_ev(9'h04D);
    send_frame(8'h4D, 1'b0, 1'b1);
    drain("high_start_4d");
    check("high_start_kd77", 128'(bus.key_down[77]), 128'd1);

    // Reset mid-frame after an E0 prefix: everything cleared, prefix forgotten.
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("midrst_key_down", bus.key_down, 128'd0);
    check("midrst_last_change", 128'(bus.last_change), 128'd0);
    push_ev(9'h01C);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("midrst_1c");
    check("midrst_kd28", bus.key_down, 128'd1 << 28);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
